// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and constants for the PUF evaluation sequencer
package puf_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SHIFT  = 3'd2,
    S_ARM    = 3'd3,
    S_EVAL   = 3'd4,
    S_SAMPLE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [31:0] LFSR_POLY     = 32'h80200003;
  localparam int          DEF_CHAL_BITS = 128;
  localparam int          DEF_RESP_BITS = 32;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ ({32{s[0]}} & LFSR_POLY);
  endfunction

endpackage

// File: rtl/puf_chal_lfsr.sv
// rtl/puf_chal_lfsr.sv - challenge LFSR; a zero seed is replaced by 1 so it never locks up
module puf_chal_lfsr
  import puf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] seed_i,
  output logic        bit_o
);

  logic [31:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lfsr_q <= 32'h1;
    else if (load_i) lfsr_q <= (seed_i == 32'h0) ? 32'h1 : seed_i;
    else if (en_i)   lfsr_q <= lfsr_step(lfsr_q);
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/sync_cell.sv
// rtl/sync_cell.sv - generic multi-flop synchroniser for a single asynchronous bit
module sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/puf_eval_seq.sv
// rtl/puf_eval_seq.sv - sequences challenge shift, PUF reset/evaluate and response packing
module puf_eval_seq
  import puf_pkg::*;
#(
  parameter int CHAL_BITS   = DEF_CHAL_BITS,
  parameter int RESP_BITS   = DEF_RESP_BITS,
  parameter int RESET_CYC   = 4,
  parameter int EVAL_CYC    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           cfg_sel,
  input  logic [1:0]           cfg_length,
  input  logic [31:0]          cfg_seed,
  input  logic [5:0]           cfg_nbits,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  output logic [1:0]           puf_sel,
  output logic [1:0]           puf_length,
  output logic                 puf_reset,
  output logic                 chal_si,
  output logic                 chal_rstn,
  output logic                 chal_clk_en,
  input  logic                 puf_out
);

  localparam int CNT_W = 16;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [5:0]           bit_cnt_q, nbits_q;
  logic [RESP_BITS-1:0] resp_q;
  logic                 busy_q, done_q, resp_valid_q, puf_reset_q;
  logic                 chal_si_q, chal_rstn_q, chal_clk_en_q;
  logic [1:0]           sel_q, len_q;
  logic                 lfsr_bit, puf_sync, shift_last, lfsr_load, lfsr_en;

  assign shift_last = (cnt_q == CNT_W'(CHAL_BITS - 1));
  assign lfsr_load  = (state_q == S_IDLE) && start && !abort;
  // Advance once per bit actually placed on chal_si, so the stream continues across bits
  assign lfsr_en    = (state_q == S_CLEAR) || ((state_q == S_SHIFT) && !shift_last);

  puf_chal_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .load_i (lfsr_load),
    .en_i   (lfsr_en),
    .seed_i (cfg_seed),
    .bit_o  (lfsr_bit)
  );

  sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (puf_out),
    .q_o   (puf_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      nbits_q       <= '0;
      resp_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      puf_reset_q   <= 1'b1;
      chal_si_q     <= 1'b0;
      chal_rstn_q   <= 1'b0;
      chal_clk_en_q <= 1'b0;
      sel_q         <= 2'd0;
      len_q         <= 2'd0;
    end else begin
      chal_rstn_q <= 1'b1;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          puf_reset_q   <= 1'b1;
          chal_clk_en_q <= 1'b0;
          if (start && !abort) begin
            sel_q        <= cfg_sel;
            len_q        <= cfg_length;
            nbits_q      <= (cfg_nbits == 6'd0 || cfg_nbits > 6'(RESP_BITS)) ?
                            6'(RESP_BITS) : cfg_nbits;
            bit_cnt_q    <= '0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b1;
            chal_rstn_q  <= 1'b0;
            state_q      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_q         <= '0;
          chal_clk_en_q <= 1'b1;
          chal_si_q     <= lfsr_bit;
          state_q       <= S_SHIFT;
        end
        S_SHIFT: begin
          if (shift_last) begin
            cnt_q         <= '0;
            chal_clk_en_q <= 1'b0;
            chal_si_q     <= 1'b0;
            state_q       <= S_ARM;
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            chal_si_q <= lfsr_bit;
          end
        end
        S_ARM: begin
          if (cnt_q == CNT_W'(RESET_CYC - 1)) begin
            cnt_q       <= '0;
            puf_reset_q <= 1'b0;
            state_q     <= S_EVAL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EVAL: begin
          if (cnt_q == CNT_W'(EVAL_CYC - 1)) begin
            puf_reset_q <= 1'b1;
            state_q     <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          resp_q    <= {resp_q[RESP_BITS-2:0], puf_sync};
          bit_cnt_q <= bit_cnt_q + 6'd1;
          if (bit_cnt_q + 6'd1 == nbits_q) begin
            done_q       <= 1'b1;
            resp_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= S_DONE;
          end else begin
            chal_rstn_q <= 1'b0;
            state_q     <= S_CLEAR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Abort overrides whatever the active state scheduled above
      if (abort && busy_q) begin
        state_q       <= S_IDLE;
        busy_q        <= 1'b0;
        done_q        <= 1'b0;
        resp_valid_q  <= 1'b0;
        puf_reset_q   <= 1'b1;
        chal_clk_en_q <= 1'b0;
        chal_si_q     <= 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign resp        = resp_q;
  assign resp_valid  = resp_valid_q;
  assign puf_sel     = sel_q;
  assign puf_length  = len_q;
  assign puf_reset   = puf_reset_q;
  assign chal_si     = chal_si_q;
  assign chal_rstn   = chal_rstn_q;
  assign chal_clk_en = chal_clk_en_q;

endmodule

// File: tb/tb_puf_eval_seq.sv
// tb/tb_puf_eval_seq.sv - scoreboard bench for puf_eval_seq
module tb_puf_eval_seq;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  cfg_sel, cfg_length;
  logic [31:0] cfg_seed;
  logic [5:0]  cfg_nbits;
  logic        busy, done, resp_valid, puf_reset, chal_si, chal_rstn, chal_clk_en;
  logic [31:0] resp;
  logic [1:0]  puf_sel, puf_length;
  logic        puf_out = 1'b0;

  puf_eval_seq dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_sel(cfg_sel), .cfg_length(cfg_length), .cfg_seed(cfg_seed), .cfg_nbits(cfg_nbits),
    .busy(busy), .done(done), .resp(resp), .resp_valid(resp_valid),
    .puf_sel(puf_sel), .puf_length(puf_length), .puf_reset(puf_reset),
    .chal_si(chal_si), .chal_rstn(chal_rstn), .chal_clk_en(chal_clk_en),
    .puf_out(puf_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  int busy_n, rl_n, crst_n, chal_n, chal_bad, done_n, done_cyc;
  int pk;
  bit pmode, chal_on;
  logic prev_pr = 1'b1;
  logic [31:0] exp_q[$];
  logic        chal_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: PUF model, chal_si scoreboard, done/resp scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_n++;
      if (!puf_reset) rl_n++;
      if (!chal_rstn) crst_n++;
      if (prev_pr && !puf_reset) begin
        puf_out = pmode ? ~pk[0] : 1'b1;
        pk++;
      end
      if (chal_clk_en && chal_on) begin
        chal_n++;
        if (chal_q.size() == 0) chal_bad++;
        else if (chal_q.pop_front() !== chal_si) chal_bad++;
      end
      if (done) begin
        done_n++;
        done_cyc = cyc - t0 + 1;
        if (exp_q.size() != 0) check("resp", resp, exp_q.pop_front());
        check("resp_valid_at_done", resp_valid, 1'b1);
      end
    end
    prev_pr = puf_reset;
  end

  task automatic check_rst(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_resp"}, resp, 32'h0);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_puf_reset"}, puf_reset, 1'b1);
    check({tag, "_chal_rstn"}, chal_rstn, 1'b0);
    check({tag, "_chal_si"}, chal_si, 1'b0);
    check({tag, "_chal_clk_en"}, chal_clk_en, 1'b0);
    check({tag, "_puf_sel"}, puf_sel, 2'd0);
    check({tag, "_puf_length"}, puf_length, 2'd0);
  endtask

  function automatic int eff_n(input logic [5:0] nb);
    return (nb == 6'd0 || nb > 6'd32) ? 32 : int'(nb);
  endfunction

  task automatic start_run(input logic [31:0] seed, input logic [5:0] nb, input logic [1:0] sel,
                           input logic [1:0] len, input bit mode, input bit exp_done);
    int n;
    logic [31:0] m, r;
    n = eff_n(nb);
    @(posedge clk); #1;
    busy_n = 0; rl_n = 0; crst_n = 0; chal_n = 0; chal_bad = 0; done_n = 0; done_cyc = 0;
    pmode = mode; pk = 0; chal_on = exp_done;
    chal_q.delete();
    if (exp_done) begin
      m = (seed == 32'h0) ? 32'h1 : seed;
      for (int i = 0; i < 128 * n; i++) begin
        chal_q.push_back(m[0]);
        m = m[0] ? ((m >> 1) ^ 32'h80200003) : (m >> 1);
      end
      r = 32'h0;
      for (int k = 0; k < n; k++) r = (r << 1) | (mode ? {31'h0, ~k[0]} : 32'h1);
      exp_q.push_back(r);
    end
    cfg_seed = seed; cfg_nbits = nb; cfg_sel = sel; cfg_length = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic finish_run(input string tag, input int n, input logic [1:0] sel, input logic [1:0] len);
    for (int i = 0; i < 160 * n + 20 && done_n == 0; i++) @(posedge clk);
    check({tag, "_done_seen"}, done_n, 1);
    check({tag, "_done_cycle"}, done_cyc, 150 * n + 1);
    check({tag, "_busy_cycles"}, busy_n, 150 * n);
    check({tag, "_puf_reset_low"}, rl_n, 16 * n);
    check({tag, "_chal_rstn_low"}, crst_n, n);
    check({tag, "_chal_bits"}, chal_n, 128 * n);
    check({tag, "_chal_bad"}, chal_bad, 0);
    check({tag, "_puf_sel"}, puf_sel, sel);
    check({tag, "_puf_length"}, puf_length, len);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_single_done"}, done_n, 1);
    check({tag, "_resp_valid_hold"}, resp_valid, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_sel = 2'd0; cfg_length = 2'd0; cfg_seed = 32'h0; cfg_nbits = 6'd0;
    chal_on = 1'b0; pmode = 1'b0; pk = 0;
    busy_n = 0; rl_n = 0; crst_n = 0; chal_n = 0; chal_bad = 0; done_n = 0; done_cyc = 0;
    repeat (3) @(posedge clk);
    #1 check_rst("rst");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("chal_rstn_release", chal_rstn, 1'b1);

    // Single bit, config latched, a second start and cfg change mid-run are ignored
    start_run(32'h1, 6'd1, 2'b10, 2'b01, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("busy_c10", busy, 1'b1);
    cfg_sel = 2'b01; cfg_length = 2'b11; cfg_seed = 32'h1234; cfg_nbits = 6'd5;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run("a", 1, 2'b10, 2'b01);

    start_run(32'h1, 6'd32, 2'b00, 2'b00, 1'b1, 1'b1);
    finish_run("b", 32, 2'b00, 2'b00);

    // Zero seed and zero nbits both fall back to their defaults
    start_run(32'h0, 6'd0, 2'b11, 2'b10, 1'b1, 1'b1);
    finish_run("c", 32, 2'b11, 2'b10);

    start_run(32'hDEADBEEF, 6'd3, 2'b01, 2'b11, 1'b1, 1'b1);
    finish_run("d", 3, 2'b01, 2'b11);

    start_run(32'h5, 6'd40, 2'b01, 2'b01, 1'b0, 1'b0);
    repeat (59) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_puf_reset", puf_reset, 1'b1);
    check("abort_clk_en", chal_clk_en, 1'b0);
    check("abort_resp_valid", resp_valid, 1'b0);
    repeat (400) @(posedge clk);
    check("abort_no_done", done_n, 0);
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", busy, 1'b0);

    start_run(32'h7, 6'd2, 2'b10, 2'b10, 1'b1, 1'b1);
    finish_run("e", 2, 2'b10, 2'b10);

    // Asynchronous reset while the PUF is evaluating
    start_run(32'h9, 6'd4, 2'b11, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 300 && puf_reset !== 1'b0; i++) @(posedge clk);
    #1 check("eval_reached", puf_reset, 1'b0);
    #2 reset = 1'b1;
    #1 check_rst("async");
    @(negedge clk) reset = 1'b0;
    chal_q.delete();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/puf_eval_seq.md
Name: puf_eval_seq

Overview:
- Evaluation sequencer for the four-PUF array: generates challenges, shifts them into the challenge chain, pulses the selected PUF's reset, waits for the race to settle and samples the PUF output.
- Packs up to RESP_BITS response bits into one word for the host (wishbone/logic-analyzer wrapper).
- Replaces manual bit-banging of si/rstn/reset from firmware; sits between the host register file and the PUF array.

Parameters:
- CHAL_BITS, 128, challenge chain length = number of shift cycles per challenge.
- RESP_BITS, 32, response word width.
- RESET_CYC, 4, cycles PUF reset is held high before each evaluation (ARM).
- EVAL_CYC, 16, cycles PUF reset is held low before sampling; must be >= SYNC_STAGES.
- SYNC_STAGES, 2, synchroniser depth on puf_out.

Ports:
- clk  in  1  system clock; also clocks the challenge chain via chal_clk_en.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; ignored while busy.
- abort  in  1  terminate the run, return to IDLE, no done.
- cfg_sel  in  2  PUF select, latched at start.
- cfg_length  in  2  PUF length code, latched at start.
- cfg_seed  in  32  LFSR seed, latched at start; 0 is replaced by 32'h1.
- cfg_nbits  in  6  response bits per run, 1..32; 0 and >32 are treated as 32.
- busy  out  1  high from the cycle after an accepted start until done/abort.
- done  out  1  one-cycle pulse when the response word is complete.
- resp  out  RESP_BITS  response word; valid while resp_valid.
- resp_valid  out  1  set with done; cleared by the next accepted start or by reset.
- puf_sel  out  2  to the array select.
- puf_length  out  2  to the array length.
- puf_reset  out  1  PUF reset; high = held.
- chal_si  out  1  serial challenge bit.
- chal_rstn  out  1  challenge chain clear, active low.
- chal_clk_en  out  1  enable for the integration clock gate on the chain clock.
- puf_out  in  1  asynchronous PUF result.

Behaviour:
- All outputs are registered.
- Reset values: busy 0, done 0, resp 0, resp_valid 0, puf_reset 1, chal_rstn 0, chal_si 0, chal_clk_en 0, puf_sel 0, puf_length 0, state IDLE, LFSR 32'h1.
- chal_rstn goes to 1 on the first clock after reset.
- FSM states: IDLE, CLEAR, SHIFT, ARM, EVAL, SAMPLE, DONE.
- IDLE:
  - puf_reset=1, chal_clk_en=0.
  - On start: latch cfg_*, load LFSR, clear bit counter and resp, drop resp_valid, go to CLEAR.
- CLEAR (1 cycle): chal_rstn=0, then SHIFT.
- SHIFT (CHAL_BITS cycles):
  - chal_clk_en=1; chal_si = LFSR[0]; LFSR advances every cycle.
  - Polynomial: x^32+x^22+x^2+x+1, Galois form.
  - The first bit shifted ends up at c[CHAL_BITS-1].
- ARM (RESET_CYC cycles): chal_clk_en=0, puf_reset=1.
- EVAL (EVAL_CYC cycles): puf_reset=0.
- SAMPLE (1 cycle):
  - Capture synchronised puf_out into resp: shift left, new bit at LSB.
  - puf_reset=1; bit counter increments.
  - If count == nbits go to DONE, else go to CLEAR.
  - The LFSR state carries over between bits.
- DONE (1 cycle): done=1, resp_valid=1, busy=0 next, then IDLE.
- Latency with defaults: 150 cycles per bit (1+128+4+16+1). done is high in cycle 150*N+1 after the start edge.
- puf_reset is low only in EVAL, so a PUF never runs while its challenge is changing.
- start while busy: ignored; no re-latching of config.
- start and abort in the same IDLE cycle: start is ignored.
- abort while busy: next state IDLE, puf_reset=1, chal_clk_en=0, no done, resp_valid stays 0.
- Asynchronous reset mid-run: immediately back to reset values; partial response is discarded.
- Synchroniser flops reset to 0.
- Unused resp bits (nbits < 32) are 0 in the upper positions.

Decomposition:
- Shared package puf_pkg holds:
  - FSM state encoding (3-bit localparams).
  - LFSR polynomial constant 32'h80200003.
  - Default CHAL_BITS/RESP_BITS.
- One sub-module puf_chal_lfsr (load, enable, seed, bit out).
- The 2-flop synchroniser reuses the existing generic sync cell.

Test Plan:
- seed=1, nbits=1, puf_out tied 1 -> done at cycle 151, resp=32'h00000001, busy high cycles 1..150, puf_reset low exactly 16 cycles.
- seed=1, nbits=32, puf_out driven by a model that toggles each SAMPLE (1,0,1,...) -> resp=32'hAAAAAAAA after 4800 cycles; chal_si stream matches the reference LFSR model for all 4096 bits.
- seed=0 -> chal_si stream identical to seed=1.
- cfg_sel=2'b10, cfg_length=2'b01 latched; change cfg_* mid-run -> puf_sel/puf_length stay 2/1 until the next start.
- abort asserted at cycle 60 (SHIFT) -> IDLE next cycle, puf_reset=1, chal_clk_en=0, no done; a following start gives a correct full run.
- Async reset asserted during EVAL -> all outputs at reset values within the same cycle; start while busy is ignored (second start at cycle 10 does not alter resp or timing).
